// File: rtl/ycbcr2rgb_if.sv
// Pixel stream bundle for ycbcr2rgb: YCbCr in, RGB out, valid/ready on both sides.
// Sync side-band lines exist only when YCBCR2RGB_SYNC_EN is defined.
interface ycbcr2rgb_if;
   logic [23:0] pixel_YCbCr;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] pixel_RGB;
   logic        out_valid;
   logic        out_ready;
`ifdef YCBCR2RGB_SYNC_EN
   logic        in_hsync;
   logic        in_vsync;
   logic        out_hsync;
   logic        out_vsync;

   modport slave  (input  pixel_YCbCr, in_valid, out_ready, in_hsync, in_vsync,
                   output in_ready, pixel_RGB, out_valid, out_hsync, out_vsync);
   modport master (output pixel_YCbCr, in_valid, out_ready, in_hsync, in_vsync,
                   input  in_ready, pixel_RGB, out_valid, out_hsync, out_vsync);
`else
   modport slave  (input  pixel_YCbCr, in_valid, out_ready,
                   output in_ready, pixel_RGB, out_valid);
   modport master (output pixel_YCbCr, in_valid, out_ready,
                   input  in_ready, pixel_RGB, out_valid);
`endif
endinterface

// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr -> RGB, 3-stage fixed-point pipeline with global stall.
// Optional hsync/vsync side-band carried with the data: define YCBCR2RGB_SYNC_EN.
module ycbcr2rgb #(
   parameter int FRAC_BITS = 10,
   parameter int K_R_CR    = 1436,
   parameter int K_G_CB    = 352,
   parameter int K_G_CR    = 731,
   parameter int K_B_CB    = 1815
) (
   input  logic       clk,
   input  logic       rst_n,
   ycbcr2rgb_if.slave bus
);

   localparam int W = 22;
   typedef logic signed [W-1:0] acc_t;

   localparam acc_t RND = acc_t'(1 << (FRAC_BITS-1));
   localparam acc_t KRC = acc_t'(K_R_CR);
   localparam acc_t KGB = acc_t'(K_G_CB);
   localparam acc_t KGR = acc_t'(K_G_CR);
   localparam acc_t KBB = acc_t'(K_B_CB);

   // vld_q[0]=S1, vld_q[1]=S2, vld_q[2]=S3 (drives out_valid)
   logic [2:0]        vld_q, vld_d;
   logic signed [8:0] y1_q, cb1_q, cr1_q;
   logic signed [8:0] y1_d, cb1_d, cr1_d;
   acc_t              y2_q, pr_q, pgb_q, pgr_q, pb_q;
   acc_t              y2_d, pr_d, pgb_d, pgr_d, pb_d;
   acc_t              r_s, g_s, b_s;
   logic [23:0]       rgb_q, rgb_d;
   logic              en;

   // The whole pipe advances together; a full output slot that is not taken freezes it.
   assign en           = ~vld_q[2] | bus.out_ready;
   assign bus.in_ready = en;

   function automatic logic [7:0] sat8(input acc_t s);
      acc_t q;
      q = s >>> FRAC_BITS;
      if (q < acc_t'(0))
         return 8'h00;
      else if (q > acc_t'(255))
         return 8'hFF;
      else
         return q[7:0];
   endfunction

   always_comb begin
      vld_d = {vld_q[1:0], bus.in_valid};
      y1_d  = $signed({1'b0, bus.pixel_YCbCr[23:16]});
      cb1_d = $signed({1'b0, bus.pixel_YCbCr[15:8]}) - 9'sd128;
      cr1_d = $signed({1'b0, bus.pixel_YCbCr[7:0]})  - 9'sd128;

      y2_d  = acc_t'(y1_q) <<< FRAC_BITS;
      pr_d  = KRC * acc_t'(cr1_q);
      pgb_d = KGB * acc_t'(cb1_q);
      pgr_d = KGR * acc_t'(cr1_q);
      pb_d  = KBB * acc_t'(cb1_q);

      r_s   = y2_q + pr_q + RND;
      g_s   = y2_q - pgb_q - pgr_q + RND;
      b_s   = y2_q + pb_q + RND;
      rgb_d = {sat8(r_s), sat8(g_s), sat8(b_s)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         y1_q  <= '0;
         cb1_q <= '0;
         cr1_q <= '0;
         y2_q  <= '0;
         pr_q  <= '0;
         pgb_q <= '0;
         pgr_q <= '0;
         pb_q  <= '0;
         rgb_q <= '0;
      end else if (en) begin
         vld_q <= vld_d;
         y1_q  <= y1_d;
         cb1_q <= cb1_d;
         cr1_q <= cr1_d;
         y2_q  <= y2_d;
         pr_q  <= pr_d;
         pgb_q <= pgb_d;
         pgr_q <= pgr_d;
         pb_q  <= pb_d;
         // Output pixel only changes when a real pixel lands; bubbles leave it intact.
         if (vld_q[1])
            rgb_q <= rgb_d;
      end
   end

   assign bus.out_valid = vld_q[2];
   assign bus.pixel_RGB = rgb_q;

`ifdef YCBCR2RGB_SYNC_EN
   logic [2:0] hs_q, vs_q;

   // Gating with in_valid keeps bubble slots sync-free so out_hsync never fires on a hole.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q <= '0;
         vs_q <= '0;
      end else if (en) begin
         hs_q <= {hs_q[1:0], bus.in_valid & bus.in_hsync};
         vs_q <= {vs_q[1:0], bus.in_valid & bus.in_vsync};
      end
   end

   assign bus.out_hsync = hs_q[2];
   assign bus.out_vsync = vs_q[2];
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: reference model on accept, compare on consume.
// Build with YCBCR2RGB_SYNC_EN defined to also cover the sync side-band.
module tb_ycbcr2rgb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ycbcr2rgb_if bus();

   ycbcr2rgb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic hs_drv = 1'b0;
   logic vs_drv = 1'b0;
`ifdef YCBCR2RGB_SYNC_EN
   assign bus.in_hsync = hs_drv;
   assign bus.in_vsync = vs_drv;
   int n_hs = 0;
`endif

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_in = 0;
   int          n_out = 0;
   logic [25:0] exp_q[$];
   int          in_cyc[$];
   int          out_cyc[$];
   logic [23:0] last_rgb = '0;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] clamp(input int v);
      if (v < 0)   return 8'h00;
      if (v > 255) return 8'hFF;
      return v[7:0];
   endfunction

   // Straight evaluation of the fixed-point conversion formulas on integers.
   function automatic logic [23:0] model(input logic [23:0] p);
      int y, cb, cr, r, g, b;
      y  = int'(p[23:16]);
      cb = int'(p[15:8]) - 128;
      cr = int'(p[7:0]) - 128;
      r  = (y * 1024 + 1436 * cr + 512) >>> 10;
      g  = (y * 1024 - 352 * cb - 731 * cr + 512) >>> 10;
      b  = (y * 1024 + 1815 * cb + 512) >>> 10;
      return {clamp(r), clamp(g), clamp(b)};
   endfunction

   // Monitor: consume first (3-cycle latency means no same-edge hazard), then accept.
   initial forever begin
      logic [25:0] e;
      @(negedge clk);
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            last_rgb = bus.pixel_RGB;
            chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rgb", 32'(bus.pixel_RGB), 32'(e[23:0]));
`ifdef YCBCR2RGB_SYNC_EN
               chk("hsync", 32'(bus.out_hsync), 32'(e[25]));
               chk("vsync", 32'(bus.out_vsync), 32'(e[24]));
               if (bus.out_hsync) n_hs++;
`endif
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            n_in++;
            in_cyc.push_back(cyc);
            exp_q.push_back({hs_drv, vs_drv, model(bus.pixel_YCbCr)});
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the pixel.
   task automatic send(input logic [23:0] p, input logic hs, input logic vs, output int waits);
      bus.pixel_YCbCr = p;
      bus.in_valid    = 1'b1;
      hs_drv          = hs;
      vs_drv          = vs;
      waits           = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waits++;
         if (waits > 50) begin
            chk("send_timeout", 32'(waits), 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 20);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   logic [23:0] vin [4] = '{24'hA1448E, 24'h648080, 24'hFF80FF, 24'h000000};
   logic [23:0] vexp[4] = '{24'hB5AC37, 24'h646464, 24'hFFA4FF, 24'h008700};

   initial begin
      int w, lat;
      logic [23:0] rgb0;
      bus.pixel_YCbCr = '0;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b1;

      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_rgb", 32'(bus.pixel_RGB), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed vectors: round trip, neutral, high and low saturation
      for (int i = 0; i < 4; i++) begin
         send(vin[i], 1'b0, 1'b0, w);
         bus.in_valid = 1'b0;
         wait_out(lat);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
         chk($sformatf("vec%0d_rgb", i), 32'(bus.pixel_RGB), 32'(vexp[i]));
         @(posedge clk);
         #1;
      end

      // Streaming: 8 back-to-back pixels, each must leave exactly 3 cycles after entry
      in_cyc.delete();
      out_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         send(24'($urandom), 1'b0, 1'b0, w);
         chk("stream_rdy", 32'(w), 32'd0);
      end
      bus.in_valid = 1'b0;
      drain();
      chk("stream_n", 32'(out_cyc.size()), 32'd8);
      for (int i = 0; i < 8 && i < out_cyc.size() && i < in_cyc.size(); i++) begin
         chk("stream_lat", 32'(out_cyc[i] - in_cyc[i]), 32'd3);
         chk("stream_seq", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
      end

      // Backpressure: 5 stalled cycles with a new pixel waiting at the input
      for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0, 1'b0, w);
      bus.pixel_YCbCr = 24'h3C5AF0;
      bus.out_ready   = 1'b0;
      rgb0 = bus.pixel_RGB;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_rgb_hold", 32'(bus.pixel_RGB), 32'(rgb0));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      drain();
      chk("bp_count", 32'(n_out), 32'(n_in));
      repeat (2) @(posedge clk);
      #1;
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_rgb_hold", 32'(bus.pixel_RGB), 32'(last_rgb));

      // Reset with pixels in flight: outputs clear at once, nothing stale follows
      for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 1'b0, w);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_rgb", 32'(bus.pixel_RGB), 32'd0);
      exp_q.delete();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      send(24'h648080, 1'b0, 1'b0, w);
      bus.in_valid = 1'b0;
      wait_out(lat);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_rgb", 32'(bus.pixel_RGB), 32'h646464);
      @(posedge clk);
      #1;
      drain();

`ifdef YCBCR2RGB_SYNC_EN
      // hsync on the 2nd pixel of a burst, with one stall while it is in the pipe
      n_hs = 0;
      for (int i = 0; i < 4; i++) send(24'($urandom), (i == 1), 1'b0, w);
      bus.in_valid = 1'b0;
      hs_drv = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
      chk("hs_count", 32'(n_hs), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      chk("global_timeout", 32'd1, 32'(n_err + 2));
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "timeout");
   end

endmodule
